// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared widths and types for the two-port stream demux
package stream_demux_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_WIDTH  = 16;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

endpackage

// File: rtl/demux_fifo2.sv
// rtl/demux_fifo2.sv - two-entry FIFO per output port, head word always visible
module demux_fifo2
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  // Pushes on a full buffer and pops on an empty one are ignored defensively.
  always_comb begin
    do_push  = push && (count_q != 2'(DEPTH));
    do_pop   = pop && (count_q != 2'd0);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full      = (count_q == 2'(DEPTH));
  assign empty     = (count_q == 2'd0);
  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/stream_demux16.sv
// rtl/stream_demux16.sv - routes one input stream to two buffered output ports
module stream_demux16
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
);

  logic full0, full1, empty0, empty1;
  logic push0, push1, pop0, pop1;
  cnt_t cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Ready depends only on the selected port's registered full flag, so a
  // stalled port never blocks traffic to the other one.
  assign in_ready   = rst_n && (in_sel ? !full1 : !full0);
  assign push0      = in_valid && in_ready && !in_sel;
  assign push1      = in_valid && in_ready && in_sel;
  assign out0_valid = !empty0;
  assign out1_valid = !empty1;
  assign pop0       = out0_valid && out0_ready;
  assign pop1       = out1_valid && out1_ready;

  demux_fifo2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .push_data (in_data),
    .pop       (pop0),
    .full      (full0),
    .empty     (empty0),
    .head_data (out0_data)
  );

  demux_fifo2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (in_data),
    .pop       (pop1),
    .full      (full1),
    .empty     (empty1),
    .head_data (out1_data)
  );

  always_comb begin
    cnt0_d = pop0 ? cnt0_q + cnt_t'(1) : cnt0_q;
    cnt1_d = pop1 ? cnt1_q + cnt_t'(1) : cnt1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;

endmodule
